// File: rtl/grf_multiport_sb.sv
// grf_multiport_sb: parametrised register file with write-to-read bypass and a per-register busy scoreboard
// Define GRF_TRACE_EN to log every accepted write as "@pc: $reg <= data".
module grf_multiport_sb #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_reg,
    output logic [NREG-1:0]       busy_vec
);
    logic [DATA_W-1:0] regFile [NREG];
    logic [NREG-1:0]   busy, setMask, clrMask;
    logic              writeOk, issueOk;

    // Index 0 and indices beyond the file never write, issue or report busy.
    assign writeOk  = we && waddr != '0 && 32'(waddr) < NREG;
    assign issueOk  = iss_valid && iss_reg != '0 && 32'(iss_reg) < NREG;
    assign clrMask  = writeOk ? NREG'(1) << waddr : '0;
    assign setMask  = issueOk ? NREG'(1) << iss_reg : '0;
    assign busy_vec = busy;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) regFile[r] <= '0;
            busy <= '0;
        end else begin
            if (writeOk) regFile[waddr] <= wdata;
            busy <= (busy & ~clrMask) | setMask;
        end
    end

    genvar i;
    for (i = 0; i < NRD; i++) begin : g_read
        logic [ADDR_W-1:0] idx;
        logic              ok, hit;
        assign idx = raddr[i*ADDR_W +: ADDR_W];
        assign ok  = idx != '0 && 32'(idx) < NREG;
        assign hit = BYPASS != 0 && writeOk && waddr == idx;
        assign rdata[i*DATA_W +: DATA_W] = !ok ? '0 : hit ? wdata : regFile[idx];
        assign rbusy[i] = ok && !hit && busy[idx];
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && writeOk) $display("@%h: $%d <= %h", pc, waddr, wdata);
    end
`else
    logic unusedPc;
    assign unusedPc = ^pc;
`endif
endmodule

// File: tb/tb_grf_multiport_sb.sv
// tb_grf_multiport_sb: scoreboard bench driving a bypassing 32-entry file and a non-bypassing 28-entry file in lockstep
module tb_grf_multiport_sb;
    logic        clk = 0, reset = 1, we = 0, iss_valid = 0;
    logic [31:0] pc = 0, wdata = 0;
    logic [4:0]  waddr = 0, iss_reg = 0;
    logic [9:0]  raddr = 0;
    logic [63:0] rdA, rdB;
    logic [1:0]  rbA, rbB;
    logic [31:0] bvA;
    logic [27:0] bvB;

    always #5 clk = ~clk;

    grf_multiport_sb #(.NREG(32), .BYPASS(1)) dutA (
        .clk(clk), .reset(reset), .pc(pc), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdA), .rbusy(rbA), .iss_valid(iss_valid), .iss_reg(iss_reg), .busy_vec(bvA));
    grf_multiport_sb #(.NREG(28), .BYPASS(0)) dutB (
        .clk(clk), .reset(reset), .pc(pc), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdB), .rbusy(rbB), .iss_valid(iss_valid), .iss_reg(iss_reg), .busy_vec(bvB));

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } entry_t;

    entry_t      sbq[$];
    logic [31:0] mReg [2][32];
    logic [31:0] mBusy [2];
    int          compared = 0, mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int nregOf(input int d);
        return d == 0 ? 32 : 28;
    endfunction

    function automatic logic [31:0] observed(input int sel);
        case (sel)
            0: return rdA[31:0];
            1: return rdA[63:32];
            2: return rdB[31:0];
            3: return rdB[63:32];
            4: return 32'(rbA[0]);
            5: return 32'(rbA[1]);
            6: return 32'(rbB[0]);
            7: return 32'(rbB[1]);
            8: return bvA;
            default: return 32'(bvB);
        endcase
    endfunction

    // Push the model's view of every output for the inputs currently driven.
    task automatic expectAll(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  idx;
                logic        ok, hit;
                idx = raddr[p*5 +: 5];
                ok  = idx != 0 && int'(idx) < nregOf(d);
                hit = d == 0 && we && waddr == idx && waddr != 0;
                sbq.push_back('{$sformatf("%s.rd%0d%s", tag, p, d ? "B" : "A"), d*2 + p,
                               !ok ? 32'h0 : hit ? wdata : mReg[d][idx]});
                sbq.push_back('{$sformatf("%s.rb%0d%s", tag, p, d ? "B" : "A"), 4 + d*2 + p,
                               32'(ok && !hit && mBusy[d][idx])});
            end
            sbq.push_back('{$sformatf("%s.bv%s", tag, d ? "B" : "A"), 8 + d, mBusy[d]});
        end
    endtask

    task automatic drain();
        #2;
        while (sbq.size() > 0) begin
            entry_t e;
            e = sbq.pop_front();
            check(e.tag, observed(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int r = 0; r < 32; r++) mReg[d][r] = 0;
                mBusy[d] = 0;
            end else begin
                if (we && waddr != 0 && int'(waddr) < nregOf(d)) begin
                    mReg[d][waddr] = wdata;
                    mBusy[d][waddr] = 1'b0;
                end
                if (iss_valid && iss_reg != 0 && int'(iss_reg) < nregOf(d)) mBusy[d][iss_reg] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        pc = pc + 4;
    endtask

    task automatic step(input string tag);
        expectAll(tag);
        drain();
        tick();
    endtask

    initial begin
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 0;
        raddr = {5'd5, 5'd0};
        expectAll("rst");
        drain();
        check("rst.bvA", bvA, 32'h0);
        check("rst.rdA", rdA[31:0], 32'h0);

        we = 1; waddr = 3; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd3};
        step("wr3");
        we = 0;
        expectAll("rd3");
        drain();
        check("rd3.A", rdA[31:0], 32'hDEADBEEF);
        check("rd3.B", rdB[31:0], 32'hDEADBEEF);

        we = 1; waddr = 0; wdata = 32'h1234; raddr = {5'd0, 5'd0};
        step("wr0");
        we = 0;
        expectAll("rd0");
        drain();
        check("rd0.A", rdA[31:0], 32'h0);

        we = 1; waddr = 7; wdata = 32'h55; raddr = {5'd7, 5'd3};
        expectAll("byp");
        drain();
        check("byp.A", rdA[63:32], 32'h55);
        check("byp.B", rdB[63:32], 32'h0);
        tick();
        we = 0;

        iss_valid = 1; iss_reg = 9; raddr = {5'd7, 5'd9};
        step("iss9");
        iss_valid = 0;
        expectAll("busy9");
        drain();
        check("busy9.bv", bvA[9], 1'b1);
        check("busy9.rb", rbA[0], 1'b1);
        tick();
        we = 1; waddr = 9; wdata = 32'h99;
        expectAll("wr9");
        drain();
        check("wr9.rbA", rbA[0], 1'b0);
        check("wr9.rbB", rbB[0], 1'b1);
        tick();
        we = 0;
        check("clr9.bv", bvA[9], 1'b0);

        iss_valid = 1; iss_reg = 4; raddr = {5'd4, 5'd4};
        step("iss4");
        we = 1; waddr = 4; wdata = 32'h44;
        step("coll4");
        we = 0; iss_valid = 0;
        check("coll4.bv", bvA[4], 1'b1);

        we = 1; waddr = 2; wdata = 32'hA5; iss_valid = 1; iss_reg = 2; raddr = {5'd6, 5'd2};
        step("wr2");
        we = 0; iss_reg = 6;
        step("iss6");
        iss_valid = 0;
        expectAll("pre");
        drain();
        check("pre.rd2", rdA[31:0], 32'hA5);
        check("pre.bv", bvA & 32'h44, 32'h44);
        reset = 1; we = 1; waddr = 5; wdata = 32'h77; iss_valid = 1; iss_reg = 5;
        tick();
        reset = 0; we = 0; iss_valid = 0; raddr = {5'd5, 5'd2};
        expectAll("post");
        drain();
        check("post.bv", bvA, 32'h0);
        check("post.rd2", rdA[31:0], 32'h0);
        check("post.rd5", rdA[63:32], 32'h0);

        we = 1; waddr = 30; wdata = 32'h3030; raddr = {5'd30, 5'd29};
        step("hiwr");
        we = 0;
        expectAll("hi");
        drain();
        check("hi.A", rdA[63:32], 32'h3030);
        check("hi.B", rdB[63:32], 32'h0);

        for (int n = 0; n < 300; n++) begin
            reset     = $urandom_range(0, 40) == 0;
            we        = $urandom_range(0, 1) == 1;
            waddr     = 5'($urandom);
            wdata     = $urandom;
            iss_valid = $urandom_range(0, 2) != 0;
            iss_reg   = 5'($urandom);
            raddr     = $urandom_range(0, 3) == 0 ? {waddr, 5'($urandom)} : 10'($urandom);
            step($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
